// File: rtl/dsi_pkg.sv
// Shared constants and types for the DSI transmit scheduler.
// Latency: none; holds only data-type codes, the state encoding and a DI helper.
// Backpressure: not applicable.
package dsi_pkg;

  // DSI data-type codes carried in DI[5:0]
  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_VSE    = 6'h11;
  localparam logic [5:0] DT_HSS    = 6'h21;
  localparam logic [5:0] DT_RGB888 = 6'h3E;
  localparam logic [5:0] DT_DCS_SW = 6'h05;

  typedef enum logic [2:0] {
    IDLE,
    VSS,
    HSS,
    LINE_WAIT,
    RGB,
    VSE,
    CMD,
    WAIT
  } sched_state_t;

  // Data identifier: virtual channel in the top two bits, data type below
  function automatic logic [7:0] make_di(input logic [1:0] vc, input logic [5:0] dt);
    return {vc, dt};
  endfunction

endpackage

// File: rtl/dsi_tx_scheduler_if.sv
// Bundle of the scheduler's video, command and lane-manager handshake signals.
// Latency: wiring only.
// Backpressure: lane_done acknowledges each pkt_start; vid_line_ready stalls RGB issue.
interface dsi_tx_scheduler_if;
  logic        vid_start;
  logic        vid_line_ready;
  logic        cmd_req;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_data;
  logic        cmd_ack;
  logic        pkt_start;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic        pkt_is_long;
  logic        lane_done;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  // Scheduler side
  modport master (
    input  vid_start, vid_line_ready, cmd_req, cmd_dt, cmd_data, lane_done,
    output cmd_ack, pkt_start, pkt_di, pkt_wc, pkt_is_long, busy, frame_done, timeout_err
  );

  // Video source / host / lane manager side
  modport slave (
    output vid_start, vid_line_ready, cmd_req, cmd_dt, cmd_data, lane_done,
    input  cmd_ack, pkt_start, pkt_di, pkt_wc, pkt_is_long, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/dsi_watchdog.sv
// Cycle counter that flags when a wait has lasted TIMEOUT enabled cycles.
// Latency: expire_o is combinational in the TIMEOUT-th enabled cycle after a clear.
// Backpressure: none; clear has priority over enable.
module dsi_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic dsi_clk,
  input  logic dsi_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart on clear, otherwise count every enabled cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge dsi_clk) begin
    if (dsi_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/dsi_tx_scheduler.sv
// Sequences VSS/HSS/RGB888/VSE packets per frame and slots host commands at line gaps.
// Latency: pkt_start two cycles after vid_start or lane_done (three into RGB via LINE_WAIT).
// Backpressure: one packet in flight, held until lane_done; watchdog aborts a stuck wait.
module dsi_tx_scheduler
  import dsi_pkg::*;
#(
  parameter int         NUM_LINES    = 4,
  parameter int         FRAME_LENGTH = 8,
  parameter logic [1:0] VC           = 2'd0,
  parameter int         TIMEOUT      = 1023
) (
  input  logic                dsi_clk,
  input  logic                dsi_rst,
  dsi_tx_scheduler_if.master  bus
);
  localparam int LW = $clog2(NUM_LINES + 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES);
  localparam logic [15:0]   RGB_WC    = 16'(FRAME_LENGTH * 3);

  sched_state_t state_q, state_d;
  sched_state_t ret_q, ret_d;          // where WAIT goes after lane_done
  sched_state_t cmd_ret_q, cmd_ret_d;  // where a command returns: IDLE or LINE_WAIT
  logic         hss_q, hss_d;          // packet in flight is an HSS (command slot follows)
  logic         vse_q, vse_d;          // packet in flight is the VSE (frame ends)
  logic [LW-1:0] line_q, line_d, line_inc;
  logic [7:0]   di_q, di_d;
  logic [15:0]  wc_q, wc_d;
  logic         long_q, long_d;
  logic         start_q, start_d;
  logic         ack_q, ack_d;
  logic         fdone_q, fdone_d;
  logic         terr_q, terr_d;
  logic         in_wait, wd_expire;

  assign in_wait  = (state_q == WAIT);
  assign line_inc = line_q + LW'(1);

  dsi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .dsi_clk  (dsi_clk),
    .dsi_rst  (dsi_rst),
    .clr_i    (!in_wait),
    .en_i     (in_wait),
    .expire_o (wd_expire)
  );

  // Next state, return bookkeeping and next packet fields
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cmd_ret_d = cmd_ret_q;
    hss_d     = hss_q;
    vse_d     = vse_q;
    line_d    = line_q;
    di_d      = di_q;
    wc_d      = wc_q;
    long_d    = long_q;
    start_d   = 1'b0;
    ack_d     = 1'b0;
    fdone_d   = 1'b0;
    terr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vid_start) begin
          state_d = VSS;
          line_d  = '0;
        end else if (bus.cmd_req) begin
          state_d   = CMD;
          cmd_ret_d = IDLE;
        end
      end
      VSS: begin
        state_d = WAIT; start_d = 1'b1; hss_d = 1'b0; vse_d = 1'b0;
        di_d = make_di(VC, DT_VSS); wc_d = '0; long_d = 1'b0;
        ret_d = HSS;
      end
      HSS: begin
        state_d = WAIT; start_d = 1'b1; hss_d = 1'b1; vse_d = 1'b0;
        di_d = make_di(VC, DT_HSS); wc_d = '0; long_d = 1'b0;
        ret_d = LINE_WAIT;
      end
      LINE_WAIT: begin
        if (bus.vid_line_ready) begin
          state_d = RGB;
        end
      end
      RGB: begin
        state_d = WAIT; start_d = 1'b1; hss_d = 1'b0; vse_d = 1'b0;
        di_d = make_di(VC, DT_RGB888); wc_d = RGB_WC; long_d = 1'b1;
        line_d = line_inc;
        ret_d  = (line_inc < LAST_LINE) ? HSS : VSE;
      end
      VSE: begin
        state_d = WAIT; start_d = 1'b1; hss_d = 1'b0; vse_d = 1'b1;
        di_d = make_di(VC, DT_VSE); wc_d = '0; long_d = 1'b0;
        ret_d = IDLE;
      end
      CMD: begin
        state_d = WAIT; start_d = 1'b1; ack_d = 1'b1; hss_d = 1'b0; vse_d = 1'b0;
        di_d = make_di(VC, bus.cmd_dt); wc_d = bus.cmd_data; long_d = 1'b0;
        ret_d = cmd_ret_q;
      end
      WAIT: begin
        // lane_done takes priority over a watchdog expiring in the same cycle
        if (bus.lane_done) begin
          if (hss_q && bus.cmd_req) begin
            state_d   = CMD;
            cmd_ret_d = LINE_WAIT;
          end else begin
            state_d = ret_q;
          end
          fdone_d = vse_q;
        end else if (wd_expire) begin
          state_d = IDLE;
          terr_d  = 1'b1;
          line_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bookkeeping and registered packet outputs
  always_ff @(posedge dsi_clk) begin
    if (dsi_rst) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      cmd_ret_q <= IDLE;
      hss_q     <= 1'b0;
      vse_q     <= 1'b0;
      line_q    <= '0;
      di_q      <= '0;
      wc_q      <= '0;
      long_q    <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      fdone_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cmd_ret_q <= cmd_ret_d;
      hss_q     <= hss_d;
      vse_q     <= vse_d;
      line_q    <= line_d;
      di_q      <= di_d;
      wc_q      <= wc_d;
      long_q    <= long_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      fdone_q   <= fdone_d;
      terr_q    <= terr_d;
    end
  end

  assign bus.pkt_start   = start_q;
  assign bus.pkt_di      = di_q;
  assign bus.pkt_wc      = wc_q;
  assign bus.pkt_is_long = long_q;
  assign bus.cmd_ack     = ack_q;
  assign bus.frame_done  = fdone_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dsi_tx_scheduler.sv
// Self-checking bench: frames and commands against a packet-list reference model.
// Latency: checks every pkt_start cycle against the triggering stimulus cycle.
// Backpressure: bench acts as lane manager with random lane_done delays and stalls.
module tb_dsi_tx_scheduler;
  import dsi_pkg::*;

  localparam int         NL  = 2;
  localparam int         FL  = 8;
  localparam int         TO  = 15;
  localparam logic [1:0] VCP = 2'd1;

  localparam int K_VSS = 0;
  localparam int K_HSS = 1;
  localparam int K_CMD = 2;
  localparam int K_RGB = 3;
  localparam int K_VSE = 4;

  typedef struct {
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
    logic        ack;
    int          cyc;
  } obs_t;

  typedef struct {
    int          kind;
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
    logic        ack;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   fd_cnt = 0, fd_cyc = -1;
  int   te_cnt = 0, te_cyc = -1;
  int   stray_ack = 0;
  obs_t obs_q[$];
  obs_t mon_r;

  dsi_tx_scheduler_if bus();

  dsi_tx_scheduler #(
    .NUM_LINES(NL), .FRAME_LENGTH(FL), .VC(VCP), .TIMEOUT(TO)
  ) dut (
    .dsi_clk (clk),
    .dsi_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: record every issued packet and every status pulse
  always @(negedge clk) begin
    if (bus.pkt_start === 1'b1) begin
      mon_r.di  = bus.pkt_di;
      mon_r.wc  = bus.pkt_wc;
      mon_r.lng = bus.pkt_is_long;
      mon_r.ack = bus.cmd_ack;
      mon_r.cyc = cyc;
      obs_q.push_back(mon_r);
    end else if (bus.cmd_ack === 1'b1) begin
      stray_ack++;
    end
    if (bus.frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
    if (bus.timeout_err === 1'b1) begin te_cnt++; te_cyc = cyc; end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed cycle %0d, required finish before it", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pkt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (obs_q.size() > 0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [5:0] dt, input logic [15:0] wc,
                              input logic lng, input logic ack, input int gap);
    exp_t e;
    e.kind = kind; e.di = {VCP, dt}; e.wc = wc; e.lng = lng; e.ack = ack; e.gap = gap;
    return e;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pkt_start"}, 32'(bus.pkt_start), 0);
    chk({tag, "_pkt_di"}, 32'(bus.pkt_di), 0);
    chk({tag, "_pkt_wc"}, 32'(bus.pkt_wc), 0);
    chk({tag, "_pkt_is_long"}, 32'(bus.pkt_is_long), 0);
    chk({tag, "_cmd_ack"}, 32'(bus.cmd_ack), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask

  // One frame. hold keeps cmd_req high throughout; otherwise plan[l] requests a command after HSS l.
  // stall: cycles vid_line_ready stays low before the first RGB. late_idx: packet acked in its last
  // watchdog cycle. abort_idx: packet never acked (timeout, or reset when abort_rst).
  task automatic run_frame(input bit hold, input logic [NL-1:0] plan, input logic [5:0] dt,
                           input logic [15:0] data, input int stall, input int late_idx,
                           input int abort_idx, input bit abort_rst);
    exp_t exp_q[$];
    exp_t e;
    obs_t o;
    bit   ok, stall_now, stall_done;
    int   trig, fd0, te0, d, line;

    exp_q.push_back(mk(K_VSS, DT_VSS, 16'd0, 1'b0, 1'b0, 2));
    for (int l = 0; l < NL; l++) begin
      exp_q.push_back(mk(K_HSS, DT_HSS, 16'd0, 1'b0, 1'b0, 2));
      if (hold || plan[l]) exp_q.push_back(mk(K_CMD, dt, data, 1'b0, 1'b1, 2));
      exp_q.push_back(mk(K_RGB, DT_RGB888, 16'(FL * 3), 1'b1, 1'b0, (l == 0 && stall > 0) ? 2 : 3));
    end
    exp_q.push_back(mk(K_VSE, DT_VSE, 16'd0, 1'b0, 1'b0, 2));

    fd0 = fd_cnt; te0 = te_cnt; line = 0; stall_done = 1'b0;
    obs_q.delete();
    bus.cmd_dt = dt; bus.cmd_data = data; bus.vid_line_ready = 1'b1;
    bus.vid_start = 1'b1;
    if (hold) bus.cmd_req = 1'b1;
    trig = cyc;
    tick();
    bus.vid_start = 1'b0;

    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      wait_pkt(ok);
      chk($sformatf("pkt%0d_arrived", i), 32'(ok), 1);
      if (!ok) begin bus.cmd_req = 1'b0; return; end
      o = obs_q.pop_front();
      chk($sformatf("pkt%0d_di", i), 32'(o.di), 32'(e.di));
      chk($sformatf("pkt%0d_wc", i), 32'(o.wc), 32'(e.wc));
      chk($sformatf("pkt%0d_long", i), 32'(o.lng), 32'(e.lng));
      chk($sformatf("pkt%0d_cmd_ack", i), 32'(o.ack), 32'(e.ack));
      chk($sformatf("pkt%0d_cycle", i), 32'(o.cyc), 32'(trig + e.gap));
      chk($sformatf("pkt%0d_busy", i), 32'(bus.busy), 1);

      if (i == abort_idx) begin
        bus.cmd_req = 1'b0;
        if (abort_rst) begin
          repeat (3) tick();
          rst = 1'b1;
          tick();
          chk_all_zero("reset_in_wait");
          tick();
          rst = 1'b0;
          tick();
          chk("reset_no_frame_done", 32'(fd_cnt), 32'(fd0));
          chk("reset_no_timeout", 32'(te_cnt), 32'(te0));
        end else begin
          repeat (TO + 3) tick();
          chk("timeout_count", 32'(te_cnt), 32'(te0 + 1));
          chk("timeout_cycle", 32'(te_cyc), 32'(o.cyc + TO));
          chk("timeout_idle", 32'(bus.busy), 0);
          chk("timeout_no_frame_done", 32'(fd_cnt), 32'(fd0));
          chk("timeout_no_more_pkts", 32'(obs_q.size()), 0);
        end
        return;
      end

      if (e.kind == K_RGB) line++;
      if (hold) bus.cmd_req = (e.kind != K_VSE);
      else      bus.cmd_req = (e.kind == K_HSS) ? plan[line] : 1'b0;

      stall_now = (stall > 0) && !stall_done && (i + 1 < exp_q.size()) && (exp_q[i + 1].kind == K_RGB);
      if (stall_now) bus.vid_line_ready = 1'b0;

      if (i == late_idx) d = (o.cyc + TO - 1) - cyc;
      else               d = $urandom_range(0, 5);
      if (d >= 2 && $urandom_range(0, 1) == 1) begin
        bus.vid_start = 1'b1;
        tick();
        bus.vid_start = 1'b0;
        d--;
      end
      repeat (d) tick();
      bus.lane_done = 1'b1;
      trig = cyc;
      tick();
      bus.lane_done = 1'b0;

      if (stall_now) begin
        repeat (stall - 1) tick();
        chk("stall_no_pkt", 32'(obs_q.size()), 0);
        chk("stall_busy", 32'(bus.busy), 1);
        bus.vid_line_ready = 1'b1;
        trig = cyc;
        stall_done = 1'b1;
      end

      if (e.kind == K_VSE) begin
        chk("frame_done_count", 32'(fd_cnt), 32'(fd0 + 1));
        chk("frame_done_cycle", 32'(fd_cyc), 32'(trig + 1));
        chk("frame_end_idle", 32'(bus.busy), 0);
        chk("frame_no_timeout", 32'(te_cnt), 32'(te0));
      end
    end
    tick();
    chk("frame_no_extra_pkt", 32'(obs_q.size()), 0);
  endtask

  // Command from IDLE; cmd_req drops while the packet is in flight
  task automatic run_cmd(input logic [5:0] dt, input logic [15:0] data);
    obs_t o;
    bit   ok;
    int   trig;
    obs_q.delete();
    bus.cmd_dt = dt; bus.cmd_data = data; bus.cmd_req = 1'b1;
    trig = cyc;
    tick();
    wait_pkt(ok);
    chk("cmd_arrived", 32'(ok), 1);
    if (!ok) begin bus.cmd_req = 1'b0; return; end
    o = obs_q.pop_front();
    bus.cmd_req = 1'b0;
    chk("cmd_di", 32'(o.di), 32'({VCP, dt}));
    chk("cmd_wc", 32'(o.wc), 32'(data));
    chk("cmd_long", 32'(o.lng), 0);
    chk("cmd_ack_with_start", 32'(o.ack), 1);
    chk("cmd_cycle", 32'(o.cyc), 32'(trig + 2));
    repeat ($urandom_range(1, 6)) tick();
    chk("cmd_busy_in_wait", 32'(bus.busy), 1);
    bus.lane_done = 1'b1;
    tick();
    bus.lane_done = 1'b0;
    tick();
    chk("cmd_busy_dropped", 32'(bus.busy), 0);
    tick();
    chk("cmd_single_pkt", 32'(obs_q.size()), 0);
  endtask

  initial begin
    int fd0, te0;
    rst = 1'b1;
    bus.vid_start = 1'b0; bus.vid_line_ready = 1'b1; bus.cmd_req = 1'b0;
    bus.cmd_dt = '0; bus.cmd_data = '0; bus.lane_done = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Plain 2-line frame
    run_frame(1'b0, '0, DT_DCS_SW, 16'h0000, 0, -1, -1, 1'b0);
    // DCS short write from IDLE
    run_cmd(DT_DCS_SW, 16'h1234);
    // cmd_req held through a frame, raised together with vid_start
    run_frame(1'b1, '0, DT_DCS_SW, 16'hBEEF, 0, -1, -1, 1'b0);
    // Line-ready stall of 20 cycles
    run_frame(1'b0, 2'b01, 6'h15, 16'hA5C3, 20, -1, -1, 1'b0);
    // Ack arriving in the last watchdog cycle still wins
    run_frame(1'b0, '0, 6'h05, 16'h0000, 0, 1, -1, 1'b0);
    // Watchdog abort on the second HSS
    run_frame(1'b0, '0, 6'h05, 16'h0000, 0, -1, 3, 1'b0);
    // Reset during the second RGB wait, then a full frame
    run_frame(1'b0, '0, 6'h05, 16'h0000, 0, -1, 4, 1'b1);
    run_frame(1'b0, 2'b10, 6'h39, 16'h00FF, 0, -1, -1, 1'b0);

    // lane_done while idle has no effect
    fd0 = fd_cnt; te0 = te_cnt;
    obs_q.delete();
    bus.lane_done = 1'b1;
    tick();
    bus.lane_done = 1'b0;
    repeat (3) tick();
    chk("idle_lane_done_busy", 32'(bus.busy), 0);
    chk("idle_lane_done_no_pkt", 32'(obs_q.size()), 0);
    chk("idle_lane_done_no_pulse", 32'(fd_cnt + te_cnt), 32'(fd0 + te0));

    // Randomised frames and commands
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0)
        run_cmd(6'($urandom_range(0, 63)), 16'($urandom));
      run_frame($urandom_range(0, 3) == 0, NL'($urandom_range(0, (1 << NL) - 1)),
                6'($urandom_range(0, 63)), 16'($urandom),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1, -1, 1'b0);
      repeat ($urandom_range(1, 4)) tick();
    end

    chk("no_stray_cmd_ack", 32'(stray_ack), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
